// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared encodings, widths, defaults and time limits for the alarm sequencer
package alarm_pkg;

  localparam int H1_W  = 2;
  localparam int DIG_W = 4;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;

  localparam int H1_MAX       = 2;
  localparam int H0_MAX_AT_20 = 3;
  localparam int M1_MAX       = 5;
  localparam int DIGIT_MAX    = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZED = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // A time is loadable only if it is a real 24h clock reading (00:00..23:59)
  function automatic logic time_valid(input logic [H1_W-1:0] h1,
                                      input logic [DIG_W-1:0] h0,
                                      input logic [DIG_W-1:0] m1,
                                      input logic [DIG_W-1:0] m0);
    logic h0_ok;
    h0_ok = (32'(h1) == H1_MAX) ? (32'(h0) <= H0_MAX_AT_20) : (32'(h0) <= DIGIT_MAX);
    return (32'(h1) <= H1_MAX) && h0_ok && (32'(m1) <= M1_MAX) && (32'(m0) <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// rtl/alarm_sequencer_if.sv - time, control and status bundle between the clock front end and the sequencer
interface alarm_sequencer_if;
  import alarm_pkg::*;

  logic             one_sec;
  logic [H1_W-1:0]  c_hour1;
  logic [DIG_W-1:0] c_hour0;
  logic [DIG_W-1:0] c_min1;
  logic [DIG_W-1:0] c_min0;
  logic             LD_alarm;
  logic [H1_W-1:0]  H_in1;
  logic [DIG_W-1:0] H_in0;
  logic [DIG_W-1:0] M_in1;
  logic [DIG_W-1:0] M_in0;
  logic             AL_ON;
  logic             STOP_al;
  logic             SNOOZE;
  logic [H1_W-1:0]  a_hour1;
  logic [DIG_W-1:0] a_hour0;
  logic [DIG_W-1:0] a_min1;
  logic [DIG_W-1:0] a_min0;
  logic             Alarm;
  logic [2:0]       state;

  modport master (
    output one_sec, c_hour1, c_hour0, c_min1, c_min0,
    output LD_alarm, H_in1, H_in0, M_in1, M_in0,
    output AL_ON, STOP_al, SNOOZE,
    input  a_hour1, a_hour0, a_min1, a_min0, Alarm, state
  );

  modport slave (
    input  one_sec, c_hour1, c_hour0, c_min1, c_min0,
    input  LD_alarm, H_in1, H_in0, M_in1, M_in0,
    input  AL_ON, STOP_al, SNOOZE,
    output a_hour1, a_hour0, a_min1, a_min0, Alarm, state
  );

endinterface

// File: rtl/alarm_time_cmp.sv
// rtl/alarm_time_cmp.sv - four-digit BCD time equality compare
module alarm_time_cmp
  import alarm_pkg::*;
(
  input  logic [H1_W-1:0]  a_hour1,
  input  logic [DIG_W-1:0] a_hour0,
  input  logic [DIG_W-1:0] a_min1,
  input  logic [DIG_W-1:0] a_min0,
  input  logic [H1_W-1:0]  b_hour1,
  input  logic [DIG_W-1:0] b_hour0,
  input  logic [DIG_W-1:0] b_min1,
  input  logic [DIG_W-1:0] b_min0,
  output logic             match
);

  assign match = (a_hour1 == b_hour1) && (a_hour0 == b_hour0) &&
                 (a_min1 == b_min1) && (a_min0 == b_min0);

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm FSM with ring/snooze timers; snooze support built only with ALARM_SNOOZE_EN
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF
) (
  input logic             clk,
  input logic             reset,
  alarm_sequencer_if.slave bus
);

  localparam logic [7:0] RING_LIM = 8'(RING_SEC);

  logic [H1_W-1:0]  a_h1_q;
  logic [DIG_W-1:0] a_h0_q;
  logic [DIG_W-1:0] a_m1_q;
  logic [DIG_W-1:0] a_m0_q;
  state_t           state_q;
  logic             alarm_q;
  logic [7:0]       ring_cnt;
  logic [7:0]       ring_inc;
  logic             ring_exp;
  logic             ld_ok;
  logic             match;

  assign ld_ok = bus.LD_alarm && time_valid(bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0);

  alarm_time_cmp u_cmp (
    .a_hour1 (bus.c_hour1),
    .a_hour0 (bus.c_hour0),
    .a_min1  (bus.c_min1),
    .a_min0  (bus.c_min0),
    .b_hour1 (a_h1_q),
    .b_hour0 (a_h0_q),
    .b_min1  (a_m1_q),
    .b_min0  (a_m0_q),
    .match   (match)
  );

  // Saturating increment; expiry fires on the tick that brings the count to the limit
  assign ring_inc = (ring_cnt == 8'hFF) ? ring_cnt : ring_cnt + 8'd1;
  assign ring_exp = bus.one_sec && (ring_inc >= RING_LIM);

`ifdef ALARM_SNOOZE_EN
  localparam logic [8:0] SNOOZE_LIM = 9'(SNOOZE_SEC);

  logic [8:0] snz_cnt;
  logic [8:0] snz_inc;
  logic       snz_exp;

  assign snz_inc = (snz_cnt == 9'h1FF) ? snz_cnt : snz_cnt + 9'd1;
  assign snz_exp = bus.one_sec && (snz_inc >= SNOOZE_LIM);
`else
  logic unused_snooze;
  assign unused_snooze = bus.SNOOZE ^ SNOOZE_SEC[0];
`endif

  // Alarm time register: only a valid load changes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_h1_q <= '0;
      a_h0_q <= '0;
      a_m1_q <= '0;
      a_m0_q <= '0;
    end else if (ld_ok) begin
      a_h1_q <= bus.H_in1;
      a_h0_q <= bus.H_in0;
      a_m1_q <= bus.M_in1;
      a_m0_q <= bus.M_in0;
    end
  end

  // Sequencer FSM: counters and Alarm default to cleared, so every state entry starts them fresh
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      alarm_q  <= 1'b0;
      ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      alarm_q  <= 1'b0;
      ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
      if (!bus.AL_ON) begin
        state_q <= ST_IDLE;
      end else if (ld_ok) begin
        state_q <= ST_ARMED;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_ARMED;
          ST_ARMED: begin
            if (match) begin
              state_q  <= ST_RINGING;
              alarm_q  <= 1'b1;
              ring_cnt <= {7'd0, bus.one_sec};
            end
          end
          ST_RINGING: begin
            if (bus.STOP_al) begin
              state_q <= ST_DONE;
`ifdef ALARM_SNOOZE_EN
            end else if (bus.SNOOZE) begin
              state_q <= ST_SNOOZED;
              snz_cnt <= {8'd0, bus.one_sec};
`endif
            end else if (ring_exp) begin
              state_q <= ST_DONE;
            end else begin
              alarm_q  <= 1'b1;
              ring_cnt <= bus.one_sec ? ring_inc : ring_cnt;
            end
          end
`ifdef ALARM_SNOOZE_EN
          ST_SNOOZED: begin
            if (bus.STOP_al) begin
              state_q <= ST_DONE;
            end else if (snz_exp) begin
              state_q <= ST_RINGING;
              alarm_q <= 1'b1;
            end else begin
              snz_cnt <= bus.one_sec ? snz_inc : snz_cnt;
            end
          end
`endif
          ST_DONE: begin
            if (!match) state_q <= ST_ARMED;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.a_hour1 = a_h1_q;
  assign bus.a_hour0 = a_h0_q;
  assign bus.a_min1  = a_m1_q;
  assign bus.a_min0  = a_m0_q;
  assign bus.Alarm   = alarm_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed self-checking bench for alarm_sequencer
module tb_alarm_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alarm_sequencer_if bus ();

  alarm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] atime();
    return {2'b00, bus.a_hour1, bus.a_hour0, bus.a_min1, bus.a_min0};
  endfunction

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
    bus.c_hour1 = h1;
    bus.c_hour0 = h0;
    bus.c_min1  = m1;
    bus.c_min0  = m0;
  endtask

  task automatic load(input logic [1:0] h1, input logic [3:0] h0,
                      input logic [3:0] m1, input logic [3:0] m0);
    bus.LD_alarm = 1'b1;
    bus.H_in1    = h1;
    bus.H_in0    = h0;
    bus.M_in1    = m1;
    bus.M_in0    = m0;
    step();
    bus.LD_alarm = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      bus.one_sec = 1'b1;
      step();
      bus.one_sec = 1'b0;
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.one_sec  = 1'b0;
    bus.LD_alarm = 1'b0;
    bus.AL_ON    = 1'b0;
    bus.STOP_al  = 1'b0;
    bus.SNOOZE   = 1'b0;
    bus.H_in1 = '0; bus.H_in0 = '0; bus.M_in1 = '0; bus.M_in0 = '0;
    set_time(2'd1, 4'd2, 4'd0, 4'd0);
    repeat (3) step();
    check("rst_state", 16'(bus.state), 16'd0);
    check("rst_alarm", 16'(bus.Alarm), 16'd0);
    check("rst_atime", atime(), 16'h0000);
    reset = 1'b1;

    bus.AL_ON = 1'b1;
    step();
    check("arm_from_idle", 16'(bus.state), 16'd1);

    load(2'd0, 4'd7, 4'd3, 4'd0);
    check("load_0730", atime(), 16'h0730);
    check("load_0730_state", 16'(bus.state), 16'd1);

    set_time(2'd0, 4'd7, 4'd2, 4'd9);
    step();
    check("pre_match_state", 16'(bus.state), 16'd1);
    check("pre_match_alarm", 16'(bus.Alarm), 16'd0);
    set_time(2'd0, 4'd7, 4'd3, 4'd0);
    step();
    check("match_ring_alarm", 16'(bus.Alarm), 16'd1);
    check("match_ring_state", 16'(bus.state), 16'd2);

    pulses(59);
    check("ring_59_alarm", 16'(bus.Alarm), 16'd1);
    check("ring_59_state", 16'(bus.state), 16'd2);
    pulses(1);
    check("ring_60_alarm", 16'(bus.Alarm), 16'd0);
    check("ring_60_state", 16'(bus.state), 16'd4);
    set_time(2'd0, 4'd7, 4'd3, 4'd1);
    step();
    check("done_next_min", 16'(bus.state), 16'd1);

    load(2'd2, 4'd4, 4'd0, 4'd0);
    check("bad_2400_atime", atime(), 16'h0730);
    check("bad_2400_state", 16'(bus.state), 16'd1);
    load(2'd1, 4'd2, 4'd6, 4'd0);
    check("bad_1260_atime", atime(), 16'h0730);
    check("bad_1260_state", 16'(bus.state), 16'd1);
    load(2'd2, 4'd3, 4'd5, 4'd9);
    check("good_2359_atime", atime(), 16'h2359);

    load(2'd0, 4'd7, 4'd3, 4'd1);
    check("ld_match_armed", 16'(bus.state), 16'd1);
    step();
    check("ld_match_ring", 16'(bus.state), 16'd2);
    bus.STOP_al = 1'b1;
    bus.SNOOZE  = 1'b1;
    step();
    bus.STOP_al = 1'b0;
    bus.SNOOZE  = 1'b0;
    check("stop_snooze_state", 16'(bus.state), 16'd4);
    check("stop_snooze_alarm", 16'(bus.Alarm), 16'd0);
    step();
    check("done_same_min", 16'(bus.state), 16'd4);
    bus.AL_ON   = 1'b0;
    bus.STOP_al = 1'b1;
    step();
    check("alon_off_state", 16'(bus.state), 16'd0);
    bus.AL_ON   = 1'b1;
    bus.STOP_al = 1'b0;
    step();
    check("rearm_state", 16'(bus.state), 16'd1);
    step();
    check("rearm_ring", 16'(bus.state), 16'd2);

    pulses(5);
    check("ring_5_state", 16'(bus.state), 16'd2);
    load(2'd0, 4'd7, 4'd3, 4'd1);
    check("reload_armed", 16'(bus.state), 16'd1);
    check("reload_alarm", 16'(bus.Alarm), 16'd0);
    step();
    check("reload_ring", 16'(bus.state), 16'd2);
    check("reload_ring_alarm", 16'(bus.Alarm), 16'd1);
    pulses(59);
    check("restart_59_alarm", 16'(bus.Alarm), 16'd1);
    pulses(1);
    check("restart_60_state", 16'(bus.state), 16'd4);

    load(2'd0, 4'd7, 4'd3, 4'd2);
    check("snz_prep_armed", 16'(bus.state), 16'd1);
    set_time(2'd0, 4'd7, 4'd3, 4'd2);
    step();
    check("snz_prep_ring", 16'(bus.state), 16'd2);
    bus.SNOOZE = 1'b1;
    step();
    bus.SNOOZE = 1'b0;
`ifdef ALARM_SNOOZE_EN
    check("snooze_state", 16'(bus.state), 16'd3);
    check("snooze_alarm", 16'(bus.Alarm), 16'd0);
    pulses(299);
    check("snooze_299_state", 16'(bus.state), 16'd3);
    pulses(1);
    check("snooze_300_state", 16'(bus.state), 16'd2);
    check("snooze_300_alarm", 16'(bus.Alarm), 16'd1);
`else
    check("snooze_ignored_state", 16'(bus.state), 16'd2);
    check("snooze_ignored_alarm", 16'(bus.Alarm), 16'd1);
`endif
    bus.STOP_al = 1'b1;
    step();
    bus.STOP_al = 1'b0;
    check("stop_state", 16'(bus.state), 16'd4);

    load(2'd0, 4'd7, 4'd3, 4'd2);
    step();
    check("pre_rst_alarm", 16'(bus.Alarm), 16'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_alarm", 16'(bus.Alarm), 16'd0);
    check("async_rst_state", 16'(bus.state), 16'd0);
    check("async_rst_atime", atime(), 16'h0000);
    step();
    reset = 1'b1;
    step();
    check("post_rst_arm", 16'(bus.state), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 The block SHALL have parameter RING_SEC, default 60, meaning the one_sec ticks of ringing before auto-silence (1..255).
REQ-002 The block SHALL have parameter SNOOZE_SEC, default 300, meaning the one_sec ticks of snooze before re-ring (1..511).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port one_sec, input, 1 bit: single-cycle 1 Hz enable pulse synchronous to clk.
REQ-006 The block SHALL have ports c_hour1 [1:0], c_hour0 [3:0], c_min1 [3:0] and c_min0 [3:0], all inputs: current time in BCD.
REQ-007 The block SHALL have ports LD_alarm, input, 1 bit (load strobe), and H_in1 [1:0], H_in0 [3:0], M_in1 [3:0], M_in0 [3:0], all inputs: the alarm time to load.
REQ-008 The block SHALL have ports AL_ON, input, 1 bit (arm enable), STOP_al, input, 1 bit (stop request) and SNOOZE, input, 1 bit (snooze request).
REQ-009 The block SHALL have ports a_hour1 [1:0], a_hour0 [3:0], a_min1 [3:0] and a_min0 [3:0], all outputs: the registered alarm time.
REQ-010 The block SHALL have port Alarm, output, 1 bit: registered ring output.
REQ-011 The block SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-012 The FSM SHALL have the states IDLE=0, ARMED=1, RINGING=2, SNOOZED=3 and DONE=4; the remaining codes SHALL return to IDLE.
REQ-013 A match SHALL be true when all four c_* digits equal the corresponding a_* digits; the match SHALL be combinational and registered into the FSM.
REQ-014 LD_alarm high with a valid time SHALL update a_* on the next clk edge; a valid time means H_in1<=2, H_in1=2 requires H_in0<=3, otherwise H_in0<=9, M_in1<=5 and M_in0<=9.
REQ-015 LD_alarm with an invalid time SHALL leave a_* and the state unchanged.
REQ-016 In IDLE, Alarm SHALL be 0; with AL_ON=1 the FSM SHALL go to ARMED.
REQ-017 In ARMED with match=1, the FSM SHALL go to RINGING and Alarm SHALL be 1 on that same edge (one clk of latency from match).
REQ-018 In RINGING, the ring counter SHALL count one_sec ticks.
REQ-019 In RINGING, STOP_al SHALL go to DONE, SNOOZE SHALL go to SNOOZED, and the counter reaching RING_SEC SHALL go to DONE; in all three cases Alarm SHALL fall on the same edge.
REQ-020 In SNOOZED, the snooze counter SHALL count one_sec ticks; reaching SNOOZE_SEC SHALL go to RINGING with the ring counter cleared, and STOP_al SHALL go to DONE.
REQ-021 DONE SHALL hold until match=0, then go to ARMED; a stopped alarm SHALL NOT re-ring in the same minute.
REQ-022 AL_ON=0 SHALL force IDLE from any state on the next edge, with Alarm=0 and the counters cleared.
REQ-023 A valid LD_alarm in RINGING, SNOOZED or DONE SHALL go to ARMED and clear the counters; if the new time matches immediately, RINGING SHALL follow on the next edge.
REQ-024 Priority on simultaneous events SHALL be AL_ON=0 > valid LD_alarm > STOP_al > SNOOZE > counter expiry > match.
REQ-025 Counters SHALL saturate, never wrap, and SHALL be cleared on every state entry.
REQ-026 A one_sec pulse coincident with a transition SHALL count toward the new state.

Reset
REQ-027 On reset=0, the block SHALL immediately set state=IDLE, Alarm=0, a_*=00:00 and both counters=0, regardless of clk.
REQ-028 Reset asserted mid-ring SHALL drop Alarm asynchronously.
REQ-029 The first valid clk edge after reset release SHALL evaluate normally.

Configuration
REQ-030 With macro ALARM_SNOOZE_EN defined, the SNOOZE input, the SNOOZED state and the snooze counter SHALL exist as specified.
REQ-031 Without ALARM_SNOOZE_EN, the SNOOZE input SHALL be ignored, the SNOOZED state and snooze counter SHALL be absent, code 3 SHALL be unreachable and SHALL decode to IDLE, and SNOOZE_SEC SHALL be unused.

Structure
REQ-032 Shared package alarm_pkg SHALL hold the state encodings, the BCD digit widths, the default RING_SEC/SNOOZE_SEC constants and the time-validity limits (2, 3, 5, 9).
REQ-033 Sub-module alarm_time_cmp SHALL contain the four-digit equality compare and SHALL be reused by the existing alarm comparison logic.

Verification
REQ-034 Scenario: reset=0 mid-RINGING -> Alarm=0 with no clk edge; state=0; a_*=00:00.
REQ-035 Scenario: load 07:30, AL_ON=1, time goes 07:29 -> 07:30 -> Alarm=1 one clk later; with no stop, after 60 one_sec pulses Alarm=0, state=DONE; at time 07:31 state=ARMED.
REQ-036 Scenario: load 24:00 or 12:60 -> a_* unchanged, state unchanged; load 23:59 -> accepted.
REQ-037 Scenario: RINGING plus SNOOZE (ALARM_SNOOZE_EN) -> Alarm=0, state=3; after 300 one_sec pulses Alarm=1; STOP_al -> state=DONE; with the macro undefined, SNOOZE has no effect.
REQ-038 Scenario: STOP_al and SNOOZE on the same cycle -> state=DONE; AL_ON=0 with STOP_al -> state=IDLE.
REQ-039 Scenario: LD_alarm valid during RINGING with the new time equal to the current time -> ARMED for one clk, then RINGING; the ring counter restarts from 0.
